floating_point_adder: RTL and testbench
=======================================

// Module: floating_point_adder
// PURPOSE
// - IEEE-754 binary16 (FP16) adder for the FP16 MAC datapath: sum = a + b.
// - One registered output stage. Combinational unpack/align/add/normalise/round feeds the output flop.
// - Serves as the accumulate stage after the FP16 multiplier. Also usable standalone.
// PARAMETERS
// - none. Format is fixed at FP16: 1 sign, 5 exponent (bias 15), 10 fraction bits.
// PORTS
// - clk        input   1   rising-edge clock. Single clock domain.
// - rst_n      input   1   reset: synchronous, active-low.
// - in_valid   input   1   a/b valid this cycle
// - a          input   16  FP16 operand A
// - b          input   16  FP16 operand B
// - out_valid  output  1   sum valid. It is in_valid delayed by 1 cycle.
// - sum        output  16  FP16 result, registered
// BEHAVIOUR
// - Reset (rst_n=0 at a rising edge): sum=16'h0000 and out_valid=0. Reset takes priority over in_valid.
// - Latency is 1 cycle. Throughput is 1 add per cycle, with no stall and no backpressure.
// - in_valid=1 at edge N: sum = round(a+b) and out_valid=1 after edge N.
// - in_valid=0 at edge N: out_valid=0 and sum holds its previous value.
// - Unpack: implicit 1 for exp!=0. Subnormals (exp=0) use an implicit 0 and effective exponent 1. There is no flush-to-zero.
// - Align: swap operands so the larger magnitude is first. Shift the smaller significand right by the exponent difference.
//   - Keep guard and round bits. OR all bits shifted out beyond them into sticky.
//   - Shift amounts >= 13 leave only the sticky bit.
// - Add when signs are equal, otherwise subtract smaller from larger. Result sign is the sign of the larger magnitude.
// - Normalise:
//   - Carry-out: shift right 1 and exp+1. The bit shifted out goes into the guard/sticky chain.
//   - Leading zeros: shift left by the LZC, but never below exponent 1. Such results stay subnormal.
// - Round to nearest, ties to even, using guard and (round|sticky).
//   - A rounding carry renormalises: fraction becomes 0 and exp+1.
// - Exact cancellation (x + -x) gives +0 (16'h0000). -0 + -0 gives -0 (16'h8000).
// - Exponent overflow after rounding gives signed infinity (exp=31, frac=0).
// - Special operands:
//   - Any NaN input gives the canonical qNaN 16'h7E00.
//   - inf + -inf gives 16'h7E00.
//   - inf + finite gives that inf. inf + same-sign inf gives that inf.
// - Zero plus finite x gives x exactly. Same-magnitude operands of equal sign simply double.
// STRUCTURE
// - Shared package fp16_pkg holds:
//   - EXP_W=5, FRAC_W=10, BIAS=15, EXP_MAX=5'h1F.
//   - QNAN=16'h7E00, POS_INF=16'h7C00, NEG_INF=16'hFC00.
//   - typedef fp16_t, a struct {sign, exp[4:0], frac[9:0]}.
// - Sub-module lzc14: combinational leading-zero counter over the 14-bit pre-normalised significand, used by the normalise step.
// - Everything else lives in one combinational block plus the output register.
// TESTING
// - Rounding with guard=1 and sticky=1 rounds up: a=16'h3B91, b=16'h31EB -> sum=16'h3C86 one cycle later.
// - Equal exponents with carry-out: a=16'h36B6, b=16'h37B6 -> 16'h3B36. Exp differs by 1: a=16'h2E74, b=16'h327C -> 16'h34DB.
// - Cancellation and subnormals: 16'h3C00 + 16'hBC00 -> 16'h0000. 16'h0001 + 16'h0001 -> 16'h0002. 16'h0400 + 16'h8001 -> 16'h03FF.
// - Overflow: 16'h7BFF + 16'h7BFF -> 16'h7C00. Specials: 16'h7C00 + 16'hFC00 -> 16'h7E00. 16'h7C01 + 16'h3C00 -> 16'h7E00.
// - Pipeline and reset: back-to-back in_valid for 10 vectors gives 10 consecutive out_valid results in order.
//   - rst_n=0 mid-stream gives sum=0 and out_valid=0 at the next edge.
// - Random: 10k vectors, all classes, compared to a reference model bit-exactly. This includes the sign of zero.

Source files
------------

// File: rtl/fp16_pkg.sv
// Shared FP16 (binary16) format definitions for the MAC datapath.
package fp16_pkg;
  localparam int          EXP_W   = 5;
  localparam int          FRAC_W  = 10;
  localparam int          BIAS    = 15;
  localparam logic [4:0]  EXP_MAX = 5'h1F;

  localparam logic [15:0] QNAN    = 16'h7E00;
  localparam logic [15:0] POS_INF = 16'h7C00;
  localparam logic [15:0] NEG_INF = 16'hFC00;

  typedef struct packed {
    logic       sign;
    logic [4:0] exp;
    logic [9:0] frac;
  } fp16_t;
endpackage

// File: rtl/lzc14.sv
// Leading-zero counter over the 14-bit pre-normalised significand; all-zero yields 14.
module lzc14 (
  input  logic [13:0] val,
  output logic [3:0]  cnt
);
  always_comb begin
    cnt = 4'd14;
    // Scanning upward means the last hit is the most significant set bit.
    for (int i = 0; i < 14; i++) begin
      if (val[i]) cnt = 4'(13 - i);
    end
  end
endmodule

// File: rtl/floating_point_adder.sv
// FP16 adder: combinational unpack/align/add/normalise/round into one output register.
module floating_point_adder
  import fp16_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        out_valid,
  output logic [15:0] sum
);

  // Right-shift {m, g, r} by d; everything shifted past r collapses into the sticky LSB.
  function automatic logic [13:0] align(input logic [10:0] m, input logic [4:0] d);
    logic [12:0] v;
    logic [12:0] mask;
    v = {m, 2'b00};
    if (d >= 5'd13) return {13'd0, |m};
    mask = (13'd1 << d) - 13'd1;
    return {v >> d, |(v & mask)};
  endfunction

  function automatic logic [15:0] sat_pack(input logic sign, input logic [15:0] mag);
    if (mag[15:10] >= 6'd31) return {sign, EXP_MAX, 10'd0};
    return {sign, mag[14:0]};
  endfunction

  // Adding the round-up to {exp, frac} lets a mantissa carry bump the exponent,
  // including the subnormal-to-normal transition.
  function automatic logic [15:0] round_pack(input logic sign, input logic [5:0] e,
                                             input logic [12:0] n);
    logic rup;
    rup = n[2] & (n[1] | n[0] | n[3]);
    return sat_pack(sign, {e, n[12:3]} + {15'd0, rup});
  endfunction

  fp16_t       fa, fb, big, sml;
  logic        swap;
  logic [4:0]  ebig_p0, esml, dexp;
  logic [10:0] mbig, msml;
  logic [14:0] lg, sg, raw_p0;
  logic        sign_p0;
  logic [3:0]  lz_p0;
  logic [4:0]  lim;
  logic [3:0]  shl;
  logic [13:0] norm;
  logic [5:0]  e6;
  logic        a_nan, b_nan, a_inf, b_inf;
  logic [15:0] res_p0;

  // Stage p0: unpack, order by magnitude, align and add/subtract
  always_comb begin
    fa      = fp16_t'(a);
    fb      = fp16_t'(b);
    swap    = b[14:0] > a[14:0];
    big     = swap ? fb : fa;
    sml     = swap ? fa : fb;
    ebig_p0 = (big.exp == 5'd0) ? 5'd1 : big.exp;
    esml    = (sml.exp == 5'd0) ? 5'd1 : sml.exp;
    mbig    = {big.exp != 5'd0, big.frac};
    msml    = {sml.exp != 5'd0, sml.frac};
    dexp    = ebig_p0 - esml;
    lg      = {1'b0, mbig, 3'b000};
    sg      = {1'b0, align(msml, dexp)};
    raw_p0  = (big.sign ^ sml.sign) ? lg - sg : lg + sg;
    sign_p0 = big.sign;
  end

  lzc14 u_lzc (
    .val (raw_p0[13:0]),
    .cnt (lz_p0)
  );

  always_comb begin
    lim  = ebig_p0 - 5'd1;
    shl  = 4'd0;
    norm = raw_p0[13:0];
    e6   = {1'b0, ebig_p0};
    if (raw_p0[14]) begin
      norm = {raw_p0[14:2], raw_p0[1] | raw_p0[0]};
      e6   = {1'b0, ebig_p0} + 6'd1;
    end else begin
      // Left shift is capped so the exponent never drops below 1 (result stays subnormal).
      shl  = ({1'b0, lz_p0} < lim) ? lz_p0 : lim[3:0];
      norm = raw_p0[13:0] << shl;
      e6   = {1'b0, ebig_p0} - {2'b00, shl};
    end

    a_nan = (&a[14:10]) & (|a[9:0]);
    b_nan = (&b[14:10]) & (|b[9:0]);
    a_inf = (&a[14:10]) & ~(|a[9:0]);
    b_inf = (&b[14:10]) & ~(|b[9:0]);

    res_p0 = round_pack(sign_p0, norm[13] ? e6 : 6'd0, norm[12:0]);
    if (a_nan | b_nan | (a_inf & b_inf & (a[15] ^ b[15]))) res_p0 = QNAN;
    else if (a_inf)                                       res_p0 = a;
    else if (b_inf)                                       res_p0 = b;
    else if (raw_p0 == 15'd0)                             res_p0 = {fa.sign & fb.sign, 15'd0};
  end

  // Stage p1: output register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      sum       <= 16'h0000;
    end else begin
      out_valid <= in_valid;
      if (in_valid) sum <= res_p0;
    end
  end

endmodule

// File: tb/tb_floating_point_adder.sv
// Self-checking bench for floating_point_adder against an exact-integer FP16 reference model.
module tb_floating_point_adder;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [15:0] a, b;
  logic        out_valid;
  logic [15:0] sum;

  int errors = 0;
  int checks = 0;
  logic [15:0] last_sum;

  floating_point_adder dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .sum       (sum)
  );

  always #5 clk = ~clk;

  // Operand value in units of 2^-24 (exact for every finite FP16).
  function automatic longint fp_val(input logic [15:0] x);
    longint m;
    int     e;
    e = int'(x[14:10]);
    m = longint'(x[9:0]);
    if (e == 0) e = 1;
    else m = m + 1024;
    m = m * (longint'(1) << (e - 1));
    return x[15] ? -m : m;
  endfunction

  function automatic logic [15:0] ref_add(input logic [15:0] x, input logic [15:0] y);
    logic   xn, yn, xi, yi, sg;
    longint s, mag, q, n, rem;
    int     e;
    logic [15:0] r;
    xn = (x[14:10] == 5'h1F) && (x[9:0] != 0);
    yn = (y[14:10] == 5'h1F) && (y[9:0] != 0);
    xi = (x[14:10] == 5'h1F) && (x[9:0] == 0);
    yi = (y[14:10] == 5'h1F) && (y[9:0] == 0);
    if (xn || yn) return 16'h7E00;
    if (xi && yi) return (x[15] == y[15]) ? x : 16'h7E00;
    if (xi) return x;
    if (yi) return y;
    s = fp_val(x) + fp_val(y);
    if (s == 0) return {x[15] & y[15], 15'd0};
    sg  = (s < 0);
    mag = sg ? -s : s;
    e = 1;
    while (mag >= (longint'(2048) << (e - 1))) e++;
    q   = longint'(1) << (e - 1);
    n   = mag / q;
    rem = mag - n * q;
    if ((rem * 2 > q) || ((rem * 2 == q) && (n % 2 == 1))) n++;
    if (n == 2048) begin
      n = 1024;
      e++;
    end
    if (e >= 31) return sg ? 16'hFC00 : 16'h7C00;
    r = 16'(n);
    if (n < 1024) return {sg, 5'd0, r[9:0]};
    return {sg, 5'(e), r[9:0]};
  endfunction

  function automatic logic [15:0] rand_op(input int cls);
    logic [15:0] v;
    v = 16'($urandom);
    case (cls)
      1: v = {v[15], 15'd0};
      2: v = {v[15], 5'd0, v[9:0]};
      3: v = {v[15], 15'h7C00};
      4: v = {v[15], 5'h1F, v[9:1], 1'b1};
      5: v = {v[15], 5'h1E, v[9:0]};
      6: v = {v[15], 5'd1, v[9:0]};
      default: ;
    endcase
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b1; a = 16'h3C00; b = 16'h3C00;
    step();
    checks++;
    if (out_valid !== 1'b0 || sum !== 16'h0000) begin
      errors++;
      $display("FAIL reset: out_valid=%b sum=%h required out_valid=0 sum=0000", out_valid, sum);
    end
    step();
    rst_n = 1'b1; in_valid = 1'b0;
    step();
    checks++;
    if (out_valid !== 1'b0 || sum !== 16'h0000) begin
      errors++;
      $display("FAIL reset_idle: out_valid=%b sum=%h required out_valid=0 sum=0000", out_valid, sum);
    end
    last_sum = 16'h0000;
  endtask

  task automatic test_directed();
    logic [15:0] va [14] = '{16'h3B91, 16'h36B6, 16'h2E74, 16'h3C00, 16'h0001, 16'h0400, 16'h7BFF,
                             16'h7C00, 16'h7C01, 16'h8000, 16'h0000, 16'h7C00, 16'h0000, 16'hFC00};
    logic [15:0] vb [14] = '{16'h31EB, 16'h37B6, 16'h327C, 16'hBC00, 16'h0001, 16'h8001, 16'h7BFF,
                             16'hFC00, 16'h3C00, 16'h8000, 16'h8000, 16'h3C00, 16'h3555, 16'hFC00};
    logic [15:0] ve [14] = '{16'h3C86, 16'h3B36, 16'h34DB, 16'h0000, 16'h0002, 16'h03FF, 16'h7C00,
                             16'h7E00, 16'h7E00, 16'h8000, 16'h0000, 16'h7C00, 16'h3555, 16'hFC00};
    for (int i = 0; i < 14; i++) begin
      a = va[i]; b = vb[i]; in_valid = 1'b1;
      step();
      checks++;
      if (out_valid !== 1'b1 || sum !== ve[i]) begin
        errors++;
        $display("FAIL directed[%0d] %h+%h: out_valid=%b sum=%h required 1 %h",
                 i, va[i], vb[i], out_valid, sum, ve[i]);
      end
      last_sum = ve[i];
    end
  endtask

  task automatic test_hold();
    in_valid = 1'b0; a = 16'h4000; b = 16'h4000;
    step();
    checks++;
    if (out_valid !== 1'b0 || sum !== last_sum) begin
      errors++;
      $display("FAIL hold: out_valid=%b sum=%h required 0 %h", out_valid, sum, last_sum);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] q[$];
    logic [15:0] e;
    for (int i = 0; i < 10; i++) begin
      a = rand_op(0); b = rand_op(0); in_valid = 1'b1;
      q.push_back(ref_add(a, b));
      step();
      e = q.pop_front();
      checks++;
      if (out_valid !== 1'b1 || sum !== e) begin
        errors++;
        $display("FAIL back_to_back[%0d]: out_valid=%b sum=%h required 1 %h", i, out_valid, sum, e);
      end
      last_sum = e;
    end
    in_valid = 1'b0;
    step();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL back_to_back_end: out_valid=%b required 0", out_valid);
    end
  endtask

  task automatic test_reset_midstream();
    a = 16'h3C00; b = 16'h4000; in_valid = 1'b1;
    step();
    checks++;
    if (out_valid !== 1'b1 || sum !== 16'h4200) begin
      errors++;
      $display("FAIL pre_reset: out_valid=%b sum=%h required 1 4200", out_valid, sum);
    end
    rst_n = 1'b0; a = 16'h4400; b = 16'h4400;
    step();
    checks++;
    if (out_valid !== 1'b0 || sum !== 16'h0000) begin
      errors++;
      $display("FAIL mid_reset: out_valid=%b sum=%h required 0 0000", out_valid, sum);
    end
    rst_n = 1'b1; in_valid = 1'b0;
    last_sum = 16'h0000;
  endtask

  task automatic test_random();
    logic [15:0] e;
    int ca, cb, mode;
    for (int i = 0; i < 10000; i++) begin
      ca = int'($urandom_range(0, 9));
      cb = int'($urandom_range(0, 9));
      mode = int'($urandom_range(0, 7));
      a = rand_op(ca);
      b = rand_op(cb);
      if (mode == 0) b = a ^ 16'h8000;
      else if (mode == 1) b = (a ^ 16'h8000) + 16'($urandom_range(0, 3));
      else if (mode == 2) b = a;
      in_valid = ($urandom_range(0, 15) != 0);
      e = in_valid ? ref_add(a, b) : last_sum;
      step();
      checks++;
      if (out_valid !== in_valid || sum !== e) begin
        errors++;
        $display("FAIL random[%0d] %h+%h v=%b: out_valid=%b sum=%h required %b %h",
                 i, a, b, in_valid, out_valid, sum, in_valid, e);
      end
      last_sum = e;
    end
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; a = 16'h0000; b = 16'h0000;
    last_sum = 16'h0000;
    #2;
    test_reset();
    test_directed();
    test_hold();
    test_back_to_back();
    test_reset_midstream();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
